// File: rtl/ifu_pkg.sv
// Shared fetch-unit types: i-cache fill request/response structs and the
// responder FSM state encoding.
package ifu_pkg;

    localparam int LINE_BYTES = 16;
    localparam int LINE_WORDS = 4;
    localparam int LINE_W     = LINE_BYTES * 8;
    localparam int WORD_W     = 32;

    typedef struct packed {
        logic        valid;
        logic [31:0] address;
    } t_cache2i_mem_req;

    typedef struct packed {
        logic              valid;
        logic [31:0]       address;
        logic [LINE_W-1:0] filled_instruction;
    } t_i_mem2cache_rsp;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RSP  = 2'd2,
        ST_COOL = 2'd3
    } t_i_mem_rsp_state;

endpackage

// File: rtl/i_mem_line_array.sv
// Instruction storage as LINE_WORDS word-wide banks: one-word write port and a
// synchronous full-line read whose register is the response data.
module i_mem_line_array
    import ifu_pkg::*;
#(
    parameter int MEM_LINES = 1024,
    localparam int IDX_W    = $clog2(MEM_LINES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [1:0]        wr_word_i,
    input  logic [WORD_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [LINE_W-1:0] rd_line_o
);

    for (genvar b = 0; b < LINE_WORDS; b++) begin : g_bank
        logic [WORD_W-1:0] mem [MEM_LINES];
        logic [WORD_W-1:0] rd_q;
        logic              wr_hit;

        assign wr_hit = wr_en_i && (wr_word_i == 2'(b));

        // Storage is never reset; only the read register is.
        always_ff @(posedge clk) begin
            if (wr_hit) begin
                mem[wr_idx_i] <= wr_data_i;
            end
        end

        // Same-edge write to the line being read is not seen: the read
        // samples the array before the write lands.
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_q <= '0;
            end else if (rd_en_i) begin
                rd_q <= mem[rd_idx_i];
            end
        end

        assign rd_line_o[WORD_W*b +: WORD_W] = rd_q;
    end

endmodule

// File: rtl/i_mem_line_rsp.sv
// Far-end instruction memory for i-cache fills: accepts a line request and
// returns the addressed 16-byte line a fixed RD_LATENCY cycles later.
module i_mem_line_rsp
    import ifu_pkg::*;
#(
    parameter int MEM_LINES  = 1024,
    parameter int RD_LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  t_cache2i_mem_req cache2i_mem_req,
    output t_i_mem2cache_rsp i_mem2cache_rsp,
    input  logic             load_en,
    input  logic [31:0]      load_addr,
    input  logic [31:0]      load_data,
    output logic             busy,
    output logic [31:0]      req_cnt
);

    localparam int         IDX_W    = $clog2(MEM_LINES);
    localparam logic [3:0] CNT_INIT = 4'(RD_LATENCY - 1);

    if (RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_bad_latency
        $error("RD_LATENCY must be in 1..15");
    end
    if ((1 << IDX_W) != MEM_LINES) begin : g_bad_lines
        $error("MEM_LINES must be a power of two");
    end

    t_i_mem_rsp_state state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      req_cnt_q, req_cnt_d;
    logic             rsp_vld_q, rsp_vld_d;
    logic [31:0]      rsp_addr_q, rsp_addr_d;

    logic             rd_en;
    logic [31:0]      rd_addr;
    logic [LINE_W-1:0] rd_line;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        req_cnt_d  = req_cnt_q;
        rsp_vld_d  = 1'b0;
        rsp_addr_d = rsp_addr_q;
        rd_en      = 1'b0;
        rd_addr    = addr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cache2i_mem_req.valid) begin
                    addr_d    = cache2i_mem_req.address;
                    cnt_d     = CNT_INIT;
                    req_cnt_d = req_cnt_q + 32'd1;
                    // Single-cycle latency reads straight off the request port.
                    if (RD_LATENCY == 1) begin
                        rd_en      = 1'b1;
                        rd_addr    = cache2i_mem_req.address;
                        rsp_vld_d  = 1'b1;
                        rsp_addr_d = cache2i_mem_req.address;
                        state_d    = ST_RSP;
                    end else begin
                        state_d    = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rd_en      = 1'b1;
                    rd_addr    = addr_q;
                    rsp_vld_d  = 1'b1;
                    rsp_addr_d = addr_q;
                    state_d    = ST_RSP;
                end
            end
            ST_RSP:  state_d = ST_COOL;
            ST_COOL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            req_cnt_q  <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            req_cnt_q  <= req_cnt_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_addr_q <= rsp_addr_d;
        end
    end

    i_mem_line_array #(
        .MEM_LINES (MEM_LINES)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (load_en),
        .wr_idx_i  (load_addr[4 +: IDX_W]),
        .wr_word_i (load_addr[3:2]),
        .wr_data_i (load_data),
        .rd_en_i   (rd_en),
        .rd_idx_i  (rd_addr[4 +: IDX_W]),
        .rd_line_o (rd_line)
    );

    assign i_mem2cache_rsp.valid              = rsp_vld_q;
    assign i_mem2cache_rsp.address            = rsp_addr_q;
    assign i_mem2cache_rsp.filled_instruction = rd_line;
    assign busy    = (state_q != ST_IDLE);
    assign req_cnt = req_cnt_q;

    // Offset and above-index address bits intentionally select nothing.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{load_addr[1:0], load_addr[31:4+IDX_W],
                                rd_addr[3:0], rd_addr[31:4+IDX_W]};

endmodule

// File: tb/tb_i_mem_line_rsp.sv
// Scoreboard bench for i_mem_line_rsp: a cycle-level reference model predicts
// each response, a negedge monitor pops and compares.
module tb_i_mem_line_rsp;
    import ifu_pkg::*;

    localparam int MEM_LINES  = 1024;
    localparam int RD_LATENCY = 4;
    localparam int NWORDS     = MEM_LINES * LINE_WORDS;

    logic             clk = 1'b0;
    logic             rst;
    t_cache2i_mem_req req;
    t_i_mem2cache_rsp rsp;
    logic             load_en;
    logic [31:0]      load_addr, load_data;
    logic             busy;
    logic [31:0]      req_cnt;

    i_mem_line_rsp #(.MEM_LINES(MEM_LINES), .RD_LATENCY(RD_LATENCY)) dut (
        .clk(clk), .rst(rst),
        .cache2i_mem_req(req), .i_mem2cache_rsp(rsp),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .busy(busy), .req_cnt(req_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0]  addr;
        logic [127:0] data;
        int           due;
    } exp_t;

    exp_t        expq[$];
    exp_t        e;
    logic [31:0] mmem [NWORDS];
    int          ecnt = 0;
    int          acc = -100;
    int          next_ok = 0;
    bit          in_flight = 0;
    bit          pend = 0;
    logic [31:0] pend_addr;
    int          pend_rd;
    logic [31:0] m_req_cnt = 0;

    function automatic logic [127:0] line_of(input logic [31:0] a);
        int b;
        b = int'((a >> 4) % MEM_LINES) * LINE_WORDS;
        return {mmem[b+3], mmem[b+2], mmem[b+1], mmem[b]};
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    // Reference model: one accept per idle window, read at acc+L-1, next
    // accept no earlier than acc+L+2; loads land after the read of an edge.
    always @(posedge clk) begin
        ecnt++;
        if (rst) begin
            pend = 0; in_flight = 0; m_req_cnt = 0; next_ok = ecnt + 1;
            expq.delete();
        end else begin
            if (ecnt >= next_ok && req.valid) begin
                acc = ecnt; in_flight = 1; pend = 1;
                pend_addr = req.address;
                pend_rd = ecnt + RD_LATENCY - 1;
                next_ok = ecnt + RD_LATENCY + 2;
                m_req_cnt++;
            end
            if (pend && pend_rd == ecnt) begin
                expq.push_back('{addr: pend_addr, data: line_of(pend_addr), due: ecnt});
                pend = 0;
            end
        end
        if (load_en) mmem[int'((load_addr >> 2) % NWORDS)] = load_data;
    end

    always @(negedge clk) begin
        if (ecnt >= 1) begin
            chk("busy", busy, in_flight && (ecnt <= acc + RD_LATENCY));
            chk("req_cnt", req_cnt, m_req_cnt);
            if (rsp.valid) begin
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL rsp_unexpected got addr=%h at edge %0d expected no response", rsp.address, ecnt);
                end else begin
                    e = expq.pop_front();
                    if (e.due != ecnt || rsp.address !== e.addr || rsp.filled_instruction !== e.data) begin
                        failures++;
                        $display("FAIL rsp got edge=%0d addr=%h data=%h expected edge=%0d addr=%h data=%h",
                                 ecnt, rsp.address, rsp.filled_instruction, e.due, e.addr, e.data);
                    end
                end
            end else if (expq.size() > 0 && expq[0].due <= ecnt) begin
                checks++; failures++;
                e = expq.pop_front();
                $display("FAIL rsp_missing got none at edge %0d expected addr=%h at edge %0d", ecnt, e.addr, e.due);
            end
        end
    end

    task automatic wait_rsp(input string nm, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp.valid && n < 40);
        if (!rsp.valid) begin
            checks++; failures++;
            $display("FAIL %s_timeout got no response expected one within 40 cycles", nm);
        end
    endtask

    task automatic idle_gap();
        req.valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    logic [127:0] old_line;
    logic [31:0]  newv;
    int           lat;

    initial begin
        rst = 1'b1; req = '0; load_en = 1'b0; load_addr = '0; load_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", rsp.valid, 0);
        chk("rst_addr", rsp.address, 0);
        chk("rst_data", rsp.filled_instruction, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", req_cnt, 0);
        rst = 1'b0;

        for (int i = 0; i < NWORDS; i++) begin
            load_en = 1'b1; load_addr = 32'(i * 4); load_data = $urandom;
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            load_addr = 32'hbee0 + 32'(k * 4);
            load_data = 32'(4 - k) << 24;
            @(negedge clk);
        end
        load_en = 1'b0;

        // Basic latency on line 0xbee
        req = '{valid: 1'b1, address: 32'h0000_beef};
        wait_rsp("latency", lat);
        chk("latency", lat, RD_LATENCY);
        chk("lat_addr", rsp.address, 32'h0000_beef);
        chk("lat_data", rsp.filled_instruction, 128'h01000000_02000000_03000000_04000000);
        chk("lat_cnt", req_cnt, 1);
        idle_gap();

        // Held request is re-served once per idle acceptance
        req = '{valid: 1'b1, address: 32'h0000_bee8};
        wait_rsp("held1", lat);
        chk("held_lat1", lat, RD_LATENCY);
        wait_rsp("held2", lat);
        chk("held_gap", lat, RD_LATENCY + 2);
        chk("held_cnt", req_cnt, 3);
        idle_gap();

        // Address change during WAIT is ignored
        req = '{valid: 1'b1, address: 32'h0000_0020};
        @(negedge clk);
        req.address = 32'h0000_0040;
        wait_rsp("addr_chg", lat);
        chk("addr_chg_addr", rsp.address, 32'h0000_0020);
        chk("addr_chg_data", rsp.filled_instruction, line_of(32'h20));
        idle_gap();

        // Index wraps modulo MEM_LINES
        req = '{valid: 1'b1, address: 32'h0001_0020};
        wait_rsp("wrap", lat);
        chk("wrap_addr", rsp.address, 32'h0001_0020);
        chk("wrap_data", rsp.filled_instruction, line_of(32'h20));
        idle_gap();

        // Load on the read edge is not visible
        old_line = line_of(32'h20);
        newv = ~old_line[31:0];
        req = '{valid: 1'b1, address: 32'h0000_0020};
        repeat (3) @(negedge clk);
        load_en = 1'b1; load_addr = 32'h20; load_data = newv;
        @(negedge clk);
        load_en = 1'b0;
        chk("rbw_valid", rsp.valid, 1);
        chk("rbw_old", rsp.filled_instruction, old_line);
        idle_gap();
        req = '{valid: 1'b1, address: 32'h0000_0020};
        wait_rsp("rbw_new", lat);
        chk("rbw_new", rsp.filled_instruction[31:0], newv);
        idle_gap();

        // Reset one cycle after acceptance
        req = '{valid: 1'b1, address: 32'h0000_0030};
        @(negedge clk);
        req.valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstw_busy", busy, 0);
        chk("rstw_cnt", req_cnt, 0);
        chk("rstw_valid", rsp.valid, 0);
        repeat (8) @(negedge clk);
        req = '{valid: 1'b1, address: 32'h0000_0050};
        wait_rsp("post_rst", lat);
        chk("post_rst_lat", lat, RD_LATENCY);
        chk("post_rst_cnt", req_cnt, 1);
        idle_gap();

        // Randomized traffic with loads and occasional resets
        for (int c = 0; c < 3000; c++) begin
            load_en   = ($urandom_range(0, 3) == 0);
            load_addr = $urandom;
            load_data = $urandom;
            rst       = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) begin
                req.valid   = ($urandom_range(0, 9) < 6);
                req.address = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 255)) << 2;
            end
            @(negedge clk);
        end
        rst = 1'b0; load_en = 1'b0; req.valid = 1'b0;
        repeat (RD_LATENCY + 6) @(negedge clk);
        chk("drain", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/i_mem_line_rsp.md
Name: i_mem_line_rsp

Overview:
- Instruction-memory responder at the far end of the i-cache fill interface.
- Accepts a line-fill request from the i-cache on cache2i_mem_req.
- After a fixed, parameterised read latency, returns one 128-bit line (4 instructions) on i_mem2cache_rsp.
- Holds a word-writable instruction array, preloaded through a side port by the bench or loader.

Parameters:
- MEM_LINES, 1024, number of 16-byte lines in the array; power of 2.
- RD_LATENCY, 4, cycles from request acceptance to response valid; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cache2i_mem_req  in  t_cache2i_mem_req  fields: valid, address[31:0]. The cache holds valid until it sees a response.
- i_mem2cache_rsp  out  t_i_mem2cache_rsp  fields: valid, address[31:0], filled_instruction[127:0].
- load_en  in  1  preload word write strobe.
- load_addr  in  32  byte address of the preload word; bits [1:0] are ignored.
- load_data  in  32  preload word.
- busy  out  1  high in every state other than IDLE.
- req_cnt  out  32  count of accepted requests; wraps modulo 2^32.

Behaviour:
- Reset and line mapping
  - Reset values: state IDLE, i_mem2cache_rsp all fields 0, busy 0, req_cnt 0, latency counter 0.
  - Array contents are not reset.
  - Line index = address[4 +: log2(MEM_LINES)]. Higher address bits are ignored, so the index wraps modulo MEM_LINES.
  - Bits [3:0] select nothing. The whole line is always returned.
  - Word order: filled_instruction[32*k +: 32] is the word at byte address line_base + 4k, for k = 0..3.
- FSM: IDLE, WAIT, RSP, COOL.
  - IDLE: if cache2i_mem_req.valid is sampled high at edge T:
    - latch the full address;
    - set counter to RD_LATENCY-1;
    - increment req_cnt;
    - go to WAIT, or to RSP if RD_LATENCY==1.
  - WAIT: decrement the counter each cycle. When it reaches 1, read the line into the response register and go to RSP.
    - Changes on the request port during WAIT are ignored. The latched address is served.
  - RSP: i_mem2cache_rsp.valid = 1 for exactly one cycle, with address = the latched full address and filled_instruction = the line.
    - This is cycle T+RD_LATENCY relative to the accepting edge. Next state is COOL.
  - COOL: one cycle in which requests are ignored, giving the cache time to drop valid. Then go to IDLE.
    - If the cache still asserts valid in IDLE, that counts as a new request and is served again.
- Response register
  - Outside RSP, rsp.valid = 0. address and filled_instruction hold their last values.
- Load port
  - The load port writes one word per cycle in any state.
  - The line read happens at the edge before RSP is entered. A load on that same edge to the same line is NOT visible (read-before-write). Any earlier load is visible.
- Reset mid-operation: return to IDLE with no response issued. The latched request is discarded and req_cnt clears.
- Simultaneous request and rst: rst wins.

Decomposition:
- Existing shared package ifu_pkg:
  - t_cache2i_mem_req and t_i_mem2cache_rsp structs;
  - LINE_BYTES=16, LINE_WORDS=4;
  - t_i_mem_rsp_state enum.
- The module is local to this block and takes MEM_LINES and RD_LATENCY as parameters, so MEM_LINES and the index width derived from it are computed in the module, not held in ifu_pkg.
- One natural sub-module: i_mem_line_array.
  - 4 word-wide banks with a one-port word write and a synchronous full-line read.
  - Owns the read-before-write rule.

Test Plan:
- Latency: preload line 0xbee (words 0x04000000, 0x03000000, 0x02000000, 0x01000000 at byte addresses 0xbee0..0xbeec). Request 0x0000_beef accepted at edge T with RD_LATENCY=4 -> rsp.valid high only at T+4, address 0x0000_beef, data 128'h01000000_02000000_03000000_04000000, req_cnt=1.
- Held request: valid held through COOL with address 0xbee8 -> exactly one response per IDLE acceptance; second response at T+6+4; req_cnt=2.
- Address change mid-WAIT: accept 0x0000_0020, change the address to 0x0000_0040 during WAIT -> response carries address 0x0000_0020 and line 2 data.
- Index wrap with MEM_LINES=1024: request 0x0001_0020 -> returns line (0x0001_0020>>4)&0x3FF = 0x002 data, address field 0x0001_0020.
- Read-before-write: load to line 2 on the edge that reads the line -> the response returns old data; a subsequent request returns the new word.
- Reset mid-WAIT: assert rst one cycle after acceptance -> no rsp.valid ever, busy=0, req_cnt=0. A request after reset is served normally with the full RD_LATENCY.
